// File: rtl/unified_mem_arb.sv
// Shared word-addressed RAM serving NUM_PORTS requesters: single-grant arbiter
// (fixed or round-robin), byte-masked writes, fixed-latency in-order responses.
module unified_mem_arb #(
  parameter int NUM_PORTS = 2,
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 8,
  parameter int LATENCY   = 1,
  parameter int RR_MODE   = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_PORTS-1:0]          request,
  input  logic [NUM_PORTS-1:0]          we_re,
  input  logic [NUM_PORTS*DATA_W/8-1:0] mask,
  input  logic [NUM_PORTS*ADDR_W-1:0]   address,
  input  logic [NUM_PORTS*DATA_W-1:0]   data_in,
  output logic [NUM_PORTS-1:0]          grant,
  output logic [NUM_PORTS-1:0]          valid,
  output logic [DATA_W-1:0]             data_out,
  output logic                          busy
);
  localparam int LANES  = DATA_W / 8;
  localparam int DEPTH  = 2 ** ADDR_W;
  localparam int PORT_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int CNT_W  = $clog2(LATENCY + 2);

  generate
    if (NUM_PORTS < 1 || NUM_PORTS > 8 || DATA_W < 8 || (DATA_W % 8) != 0 ||
        ADDR_W < 1 || LATENCY < 1 || LATENCY > 4 || (RR_MODE != 0 && RR_MODE != 1))
    begin : g_param_check
      $error("unified_mem_arb: parameter out of range");
    end
  endgenerate

  logic [PORT_W-1:0] rr_ptr_reg;
  logic [PORT_W-1:0] rr_cand;
  logic              grant_any;
  logic [PORT_W-1:0] grant_idx;

  // Round-robin scans the ports strictly after the last winner, wrapping.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    rr_cand   = '0;
    if (RR_MODE == 1) begin
      for (int k = 1; k <= NUM_PORTS; k++) begin
        rr_cand = PORT_W'((int'(rr_ptr_reg) + k) % NUM_PORTS);
        if (!grant_any && request[rr_cand]) begin
          grant_any = 1'b1;
          grant_idx = rr_cand;
        end
      end
    end else begin
      for (int k = NUM_PORTS - 1; k >= 0; k--) begin
        if (request[k]) begin
          grant_any = 1'b1;
          grant_idx = PORT_W'(k);
        end
      end
    end
    if (rst) begin
      grant_any = 1'b0;
      grant_idx = '0;
    end
  end

  always_comb begin
    grant = '0;
    if (grant_any) grant[grant_idx] = 1'b1;
  end

  logic              sel_we;
  logic [LANES-1:0]  sel_mask;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;

  assign sel_we   = we_re[grant_idx];
  assign sel_mask = mask[int'(grant_idx)*LANES +: LANES];
  assign sel_addr = address[int'(grant_idx)*ADDR_W +: ADDR_W];
  assign sel_data = data_in[int'(grant_idx)*DATA_W +: DATA_W];

  // Storage is never reset; the read word is captured at the accept edge.
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_data_reg;

  always_ff @(posedge clk) begin
    if (grant_any) begin
      if (sel_we) begin
        for (int b = 0; b < LANES; b++) begin
          if (sel_mask[b]) mem[sel_addr][b*8 +: 8] <= sel_data[b*8 +: 8];
        end
      end
      rd_data_reg <= mem[sel_addr];
    end
  end

  logic              pipe_valid_reg [LATENCY];
  logic              pipe_read_reg  [LATENCY];
  logic [PORT_W-1:0] pipe_port_reg  [LATENCY];
  logic [CNT_W-1:0]  count_reg;
  logic [CNT_W-1:0]  count_next;
  logic              out_valid;
  logic              out_read;
  logic [PORT_W-1:0] out_port;
  logic [DATA_W-1:0] out_data;

  assign out_valid  = pipe_valid_reg[LATENCY-1];
  assign out_read   = pipe_read_reg[LATENCY-1];
  assign out_port   = pipe_port_reg[LATENCY-1];
  assign count_next = count_reg + CNT_W'(grant_any) - CNT_W'(out_valid);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < LATENCY; k++) begin
        pipe_valid_reg[k] <= 1'b0;
        pipe_read_reg[k]  <= 1'b0;
        pipe_port_reg[k]  <= '0;
      end
      rr_ptr_reg <= PORT_W'(NUM_PORTS - 1);
      count_reg  <= '0;
    end else begin
      pipe_valid_reg[0] <= grant_any;
      pipe_read_reg[0]  <= grant_any & ~sel_we;
      pipe_port_reg[0]  <= grant_idx;
      for (int k = 1; k < LATENCY; k++) begin
        pipe_valid_reg[k] <= pipe_valid_reg[k-1];
        pipe_read_reg[k]  <= pipe_read_reg[k-1];
        pipe_port_reg[k]  <= pipe_port_reg[k-1];
      end
      if (grant_any) rr_ptr_reg <= grant_idx;
      count_reg <= count_next;
    end
  end

  // Read data rides a parallel delay line; it is only looked at when qualified.
  generate
    if (LATENCY == 1) begin : g_lat1
      assign out_data = rd_data_reg;
    end else begin : g_latn
      logic [DATA_W-1:0] dly_reg [LATENCY-1];
      always_ff @(posedge clk) begin
        dly_reg[0] <= rd_data_reg;
        for (int k = 1; k < LATENCY - 1; k++) dly_reg[k] <= dly_reg[k-1];
      end
      assign out_data = dly_reg[LATENCY-2];
    end
  endgenerate

  genvar gi;
  generate
    for (gi = 0; gi < NUM_PORTS; gi++) begin : g_valid
      assign valid[gi] = out_valid && (out_port == PORT_W'(gi));
    end
  endgenerate

  assign data_out = (out_valid && out_read) ? out_data : '0;
  assign busy     = (count_reg != '0);

endmodule
